// File: rtl/seq_calculator.sv
// seq_calculator: WIDTH-bit accumulator calculator for the DE board.
//   A debounced push button executes acc <= acc OP operand. Operand, accumulator
//   and an overflow digit are shown on active-low seven-segment displays.
//
// Optional feature: define CALC_MUL_EN to build the shift-add multiplier (op 11).
//   Without it, op 11 leaves acc unchanged, sets ovf and never asserts busy.
//
// Ports:
//   CLOCK_50   system clock, rising edge
//   RESET      asynchronous active-high reset
//   SW         [WIDTH-1:0] operand, [WIDTH+1:WIDTH] opcode
//   KEY_EXEC   execute button, active-low, asynchronous to CLOCK_50
//   HEX_OPD    operand digits, one per nibble of SW
//   HEX_ACC    accumulator digits plus top overflow digit (0/1)
//   LEDR_BUSY  high while a multiply runs
//   LEDR_OVF   overflow flag of the last completed operation
module seq_calculator #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned DEBOUNCE_CYC = 500000
) (
  input  logic                     CLOCK_50,
  input  logic                     RESET,
  input  logic [WIDTH+1:0]         SW,
  input  logic                     KEY_EXEC,
  output logic [7*(WIDTH/4)-1:0]   HEX_OPD,
  output logic [7*(WIDTH/4+1)-1:0] HEX_ACC,
  output logic                     LEDR_BUSY,
  output logic                     LEDR_OVF
);

  localparam int unsigned NumDigits = WIDTH / 4;
  localparam int unsigned DbW       = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYC - 1);

  localparam logic [1:0] OpLoad = 2'b00;
  localparam logic [1:0] OpAdd  = 2'b01;
  localparam logic [1:0] OpSub  = 2'b10;
  localparam logic [1:0] OpMul  = 2'b11;

  typedef enum logic {
    StIdle   = 1'b0,
    StMulRun = 1'b1
  } state_e;

  // Key synchroniser and debouncer. All key state resets to "released" (high).
  logic           key_meta_q, key_sync_q, key_prev_q;
  logic           key_stable_q, key_stable_d;
  logic [DbW-1:0] db_cnt_q, db_cnt_d;
  logic           exec;

  always_comb begin
    key_stable_d = key_stable_q;
    db_cnt_d     = db_cnt_q;
    if (key_sync_q != key_prev_q) begin
      // Any raw change restarts the stability count.
      db_cnt_d = '0;
    end else if (key_sync_q != key_stable_q) begin
      if (db_cnt_q == DbLast) begin
        key_stable_d = key_sync_q;
        db_cnt_d     = '0;
      end else begin
        db_cnt_d = db_cnt_q + DbW'(1);
      end
    end else begin
      db_cnt_d = '0;
    end
  end

  // One-cycle pulse on an accepted press; release produces nothing.
  assign exec = key_stable_q & ~key_stable_d;

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      key_meta_q   <= 1'b1;
      key_sync_q   <= 1'b1;
      key_prev_q   <= 1'b1;
      key_stable_q <= 1'b1;
      db_cnt_q     <= '0;
    end else begin
      key_meta_q   <= KEY_EXEC;
      key_sync_q   <= key_meta_q;
      key_prev_q   <= key_sync_q;
      key_stable_q <= key_stable_d;
      db_cnt_q     <= db_cnt_d;
    end
  end

  // Calculator core.
  logic [WIDTH-1:0] opd;
  logic [1:0]       op;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  state_e           state_q, state_d;
  logic [WIDTH:0]   sum_w, diff_w;

  assign opd    = SW[WIDTH-1:0];
  assign op     = SW[WIDTH+1:WIDTH];
  assign sum_w  = {1'b0, acc_q} + {1'b0, opd};
  // Top bit of the extended difference is the borrow (opd > acc).
  assign diff_w = {1'b0, acc_q} - {1'b0, opd};

`ifdef CALC_MUL_EN
  localparam int unsigned BitW        = $clog2(WIDTH);
  localparam logic [BitW-1:0] BitLast = BitW'(WIDTH - 1);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [BitW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [2*WIDTH-1:0] prod_next;

  assign prod_next = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
`ifdef CALC_MUL_EN
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    prod_d    = prod_q;
    bit_cnt_d = bit_cnt_q;
`endif
    case (state_q)
      StIdle: begin
        if (exec) begin
          unique case (op)
            OpLoad: begin
              acc_d = opd;
              ovf_d = 1'b0;
            end
            OpAdd: begin
              acc_d = sum_w[WIDTH-1:0];
              ovf_d = sum_w[WIDTH];
            end
            OpSub: begin
              acc_d = diff_w[WIDTH-1:0];
              ovf_d = diff_w[WIDTH];
            end
            OpMul: begin
`ifdef CALC_MUL_EN
              // Snapshot both operands so SW changes cannot disturb the run.
              mcand_d   = {{WIDTH{1'b0}}, opd};
              mplier_d  = acc_q;
              prod_d    = '0;
              bit_cnt_d = '0;
              state_d   = StMulRun;
`else
              ovf_d = 1'b1;
`endif
            end
          endcase
        end
      end
      StMulRun: begin
`ifdef CALC_MUL_EN
        // Exec pulses are ignored here: dropped, not queued.
        mcand_d   = mcand_q << 1;
        mplier_d  = mplier_q >> 1;
        prod_d    = prod_next;
        bit_cnt_d = bit_cnt_q + BitW'(1);
        if (bit_cnt_q == BitLast) begin
          acc_d   = prod_next[WIDTH-1:0];
          ovf_d   = |prod_next[2*WIDTH-1:WIDTH];
          state_d = StIdle;
        end
`else
        state_d = StIdle;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef CALC_MUL_EN
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      prod_q    <= '0;
      bit_cnt_q <= '0;
    end else begin
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      prod_q    <= prod_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign LEDR_BUSY = (state_q == StMulRun);
`else
  assign LEDR_BUSY = 1'b0;
`endif

  assign LEDR_OVF = ovf_q;

  // Active-low segments, bit0 = a .. bit6 = g.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    s = 7'b1111111;
    unique case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
    endcase
    return s;
  endfunction

  for (genvar g = 0; g < NumDigits; g++) begin : gen_digits
    assign HEX_OPD[7*g +: 7] = hex7(SW[4*g +: 4]);
    assign HEX_ACC[7*g +: 7] = hex7(acc_q[4*g +: 4]);
  end
  assign HEX_ACC[7*NumDigits +: 7] = hex7({3'b000, ovf_q});

endmodule

// File: tb/tb_seq_calculator.sv
module tb_seq_calculator;

  localparam int unsigned W  = 8;
  localparam int unsigned W2 = 32;

  localparam logic [1:0] OpLoad = 2'b00;
  localparam logic [1:0] OpAdd  = 2'b01;
  localparam logic [1:0] OpSub  = 2'b10;
  localparam logic [1:0] OpMul  = 2'b11;

  logic clk = 1'b0;
  logic rst;
  logic [W+1:0]           sw;
  logic                   key;
  logic [7*(W/4)-1:0]     hex_opd;
  logic [7*(W/4+1)-1:0]   hex_acc;
  logic                   busy, ovf;
  logic [W2+1:0]          sw2;
  logic                   key2;
  logic [7*(W2/4)-1:0]    hex_opd2;
  logic [7*(W2/4+1)-1:0]  hex_acc2;
  logic                   busy2, ovf2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_calculator #(.WIDTH(W), .DEBOUNCE_CYC(4)) u_dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .SW       (sw),
    .KEY_EXEC (key),
    .HEX_OPD  (hex_opd),
    .HEX_ACC  (hex_acc),
    .LEDR_BUSY(busy),
    .LEDR_OVF (ovf)
  );

  // Wide instance: long multiply leaves room to press again while busy.
  seq_calculator #(.WIDTH(W2), .DEBOUNCE_CYC(4)) u_dut_w32 (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .SW       (sw2),
    .KEY_EXEC (key2),
    .HEX_OPD  (hex_opd2),
    .HEX_ACC  (hex_acc2),
    .LEDR_BUSY(busy2),
    .LEDR_OVF (ovf2)
  );

  typedef struct packed {
    logic        sel;
    logic [62:0] hex;
    logic [55:0] opd;
    logic        ovf;
    logic        busy;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    busy_len_q[$];

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [62:0] glyphs(input logic [31:0] v, input int nd);
    logic [62:0] r;
    r = '0;
    for (int k = 0; k < nd; k++) r[7*k +: 7] = glyph(v[4*k +: 4]);
    return r;
  endfunction

  // Push expected idle display state; the monitor compares at the next negedge.
  task automatic expect_state(input string nm, input logic sel, input logic [31:0] acc,
                              input logic o, input logic [31:0] opd);
    exp_t        e;
    logic [62:0] t;
    int          nd;
    nd     = sel ? 8 : 2;
    e.sel  = sel;
    e.hex  = glyphs(acc, nd) | (63'(glyph({3'b000, o})) << (7 * nd));
    t      = glyphs(opd, nd);
    e.opd  = t[55:0];
    e.ovf  = o;
    e.busy = 1'b0;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic drive_key(input logic sel, input logic v);
    if (sel) key2 = v;
    else key = v;
  endtask

  task automatic press(input logic sel, input logic [1:0] op, input logic [31:0] opd);
    @(posedge clk);
    #2;
    if (sel) sw2 = {op, opd};
    else sw = {op, opd[7:0]};
    @(posedge clk);
    #2 drive_key(sel, 1'b0);
    repeat (12) @(posedge clk);
    #2 drive_key(sel, 1'b1);
    repeat (12) @(posedge clk);
    for (int i = 0; i < 80 && (sel ? busy2 : busy); i++) @(posedge clk);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t        e;
    string       nm;
    logic [62:0] ah;
    logic [55:0] ao;
    logic        aovf, abusy;
    if (exp_q.size() > 0) begin
      e     = exp_q.pop_front();
      nm    = name_q.pop_front();
      ah    = {42'd0, hex_acc};
      ao    = {42'd0, hex_opd};
      aovf  = ovf;
      abusy = busy;
      if (e.sel) begin
        ah    = hex_acc2;
        ao    = hex_opd2;
        aovf  = ovf2;
        abusy = busy2;
      end
      checks++;
      if (ah !== e.hex || ao !== e.opd || aovf !== e.ovf || abusy !== e.busy) begin
        errors++;
        $display("FAIL %s: got hex_acc=%h hex_opd=%h ovf=%b busy=%b, want hex_acc=%h hex_opd=%h ovf=%b busy=%b",
                 nm, ah, ao, aovf, abusy, e.hex, e.opd, e.ovf, e.busy);
      end
    end
  end

  // Busy run-length monitor for the narrow instance.
  int   busy_run  = 0;
  logic busy_prev = 1'b0;
  always @(negedge clk) begin
    int x;
    if (busy === 1'b1) begin
      busy_run++;
    end else if (busy_prev) begin
      checks++;
      if (busy_len_q.size() == 0) begin
        errors++;
        $display("FAIL busy_len: got unexpected busy run of %0d cycles, want none", busy_run);
      end else begin
        x = busy_len_q.pop_front();
        if (busy_run != x) begin
          errors++;
          $display("FAIL busy_len: got %0d cycles, want %0d", busy_run, x);
        end
      end
      busy_run = 0;
    end
    busy_prev = (busy === 1'b1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic seen;
    rst  = 1'b1;
    key  = 1'b1;
    key2 = 1'b1;
    sw   = 10'h012;
    sw2  = '0;
    repeat (3) @(posedge clk);
    #2;
    expect_state("reset", 0, 32'h00, 1'b0, 32'h12);
    @(posedge clk);
    #2 rst = 1'b0;

    press(0, OpLoad, 32'hF0); expect_state("load_f0", 0, 32'hF0, 1'b0, 32'hF0);
    press(0, OpAdd,  32'h20); expect_state("add_carry", 0, 32'h10, 1'b1, 32'h20);
    press(0, OpAdd,  32'h01); expect_state("add_nocarry", 0, 32'h11, 1'b0, 32'h01);
    press(0, OpSub,  32'h11); expect_state("sub_equal", 0, 32'h00, 1'b0, 32'h11);
    press(0, OpLoad, 32'h05); expect_state("load_05", 0, 32'h05, 1'b0, 32'h05);
    press(0, OpSub,  32'h07); expect_state("sub_borrow", 0, 32'hFE, 1'b1, 32'h07);

    // Two short low glitches must not execute the pending ADD.
    @(posedge clk);
    #2 sw = {OpAdd, 8'h01};
    for (int g = 0; g < 2; g++) begin
      @(posedge clk); #2 key = 1'b0;
      repeat (2) @(posedge clk); #2 key = 1'b1;
      repeat (6) @(posedge clk);
    end
    repeat (10) @(posedge clk);
    expect_state("bounce_ignored", 0, 32'hFE, 1'b1, 32'h01);

    press(0, OpLoad, 32'hAB); expect_state("load_ab", 0, 32'hAB, 1'b0, 32'hAB);
    press(0, OpLoad, 32'hFF); expect_state("load_ff", 0, 32'hFF, 1'b0, 32'hFF);
    press(0, OpAdd,  32'h01); expect_state("add_wrap", 0, 32'h00, 1'b1, 32'h01);

    press(1, OpLoad, 32'hFFFF_FFFF);
    expect_state("w32_load", 1, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF);
    press(1, OpAdd, 32'h1); expect_state("w32_add_wrap", 1, 32'h0, 1'b1, 32'h1);

`ifdef CALC_MUL_EN
    press(0, OpLoad, 32'h0C); expect_state("load_0c", 0, 32'h0C, 1'b0, 32'h0C);
    busy_len_q.push_back(8);
    press(0, OpMul, 32'h15); expect_state("mul_fc", 0, 32'hFC, 1'b0, 32'h15);
    busy_len_q.push_back(8);
    press(0, OpMul, 32'h02); expect_state("mul_ovf", 0, 32'hF8, 1'b1, 32'h02);

    // Reset on the third cycle of a multiply.
    press(0, OpLoad, 32'h0C); expect_state("load_0c_b", 0, 32'h0C, 1'b0, 32'h0C);
    busy_len_q.push_back(3);
    @(posedge clk); #2 sw = {OpMul, 8'h15};
    @(posedge clk); #2 key = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      seen = busy;
    end
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    key = 1'b1;
    expect_state("reset_mid_mul", 0, 32'h00, 1'b0, 32'h15);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Press during a long multiply is dropped; SW change does not disturb it.
    press(1, OpLoad, 32'h3); expect_state("w32_load_3", 1, 32'h3, 1'b0, 32'h3);
    @(posedge clk); #2 sw2 = {OpMul, 32'h5};
    @(posedge clk); #2 key2 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      seen = busy2;
    end
    @(posedge clk); #2 key2 = 1'b1;
    repeat (8) @(posedge clk);
    #2 sw2 = {OpLoad, 32'h77};
    key2 = 1'b0;
    repeat (8) @(posedge clk);
    #2 key2 = 1'b1;
    for (int i = 0; i < 60 && busy2; i++) @(posedge clk);
    repeat (12) @(posedge clk);
    expect_state("w32_mul_busy_drop", 1, 32'hF, 1'b0, 32'h77);
`else
    press(0, OpLoad, 32'h33); expect_state("load_33", 0, 32'h33, 1'b0, 32'h33);
    press(0, OpMul,  32'h55); expect_state("mul_noop", 0, 32'h33, 1'b1, 32'h55);
`endif

    for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    checks++;
    if (busy_len_q.size() != 0) begin
      errors++;
      $display("FAIL busy_missing: got %0d expected busy runs unseen, want 0", busy_len_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
